fwd_stall_unit: RTL and testbench

- Parametrised forwarding and load-use hazard block for the 16-bit pipelined core.
- Owns the ID/EX source-operand register and the destination-tag pipeline for the EX, MEM and WB slots.
- Each cycle it selects the freshest value for every EX source operand and produces the forward-select codes.
- Detects load-use hazards and stalls ID while inserting a bubble into EX.

---
 rtl/fwd_stall_unit.sv | 155 +++++++++++++++
 tb/tb_fwd_stall_unit.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_stall_unit.sv
// EX operand forwarding, WB->ID bypass and load-use stall control for the 16-bit core.
// Optional FWD_STATS_EN adds saturating forward/stall counters.
module fwd_stall_unit #(
  parameter int DATA_W   = 16,
  parameter int REG_AW   = 4,
  parameter int NUM_SRC  = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      id_valid,
  input  logic [NUM_SRC*REG_AW-1:0] id_src_addr,
  input  logic [NUM_SRC-1:0]        id_src_used,
  input  logic [NUM_SRC*DATA_W-1:0] id_src_data,
  input  logic [REG_AW-1:0]         id_dst_addr,
  input  logic                      id_wr_en,
  input  logic                      id_is_load,
  input  logic                      flush,
  input  logic [DATA_W-1:0]         exmem_data,
  input  logic [DATA_W-1:0]         memwb_data,
  output logic [NUM_SRC*DATA_W-1:0] ex_op,
  output logic [NUM_SRC*2-1:0]      fwd_sel,
  output logic                      stall,
  output logic                      ex_valid,
  output logic [REG_AW-1:0]         ex_dst_addr,
  output logic                      ex_wr_en
`ifdef FWD_STATS_EN
  ,
  output logic [15:0]               stat_fwd_mem,
  output logic [15:0]               stat_fwd_wb,
  output logic [15:0]               stat_stall
`endif
);

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] dst;
    logic              wr;
    logic              load;
  } tag_t;

  typedef enum logic {RUN = 1'b0, STALL = 1'b1} state_t;

  tag_t              ex_q, mem_q;
  logic              wb_valid, wb_wr;
  logic [REG_AW-1:0] wb_dst;
  state_t            state_q, state_d;
  logic              hazard, advance;
  logic [NUM_SRC-1:0] ld_hit, mem_fwd, wb_fwd;

  function automatic logic hit(input logic v, input logic w,
                               input logic [REG_AW-1:0] d, input logic [REG_AW-1:0] a);
    return v && w && (d == a) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  assign hazard  = id_valid && ex_q.load && (|ld_hit);
  assign advance = !stall && !flush;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    logic [REG_AW-1:0] id_a, addr_q;
    logic [DATA_W-1:0] op_q;

    assign id_a       = id_src_addr[g*REG_AW +: REG_AW];
    assign ld_hit[g]  = id_src_used[g] && hit(ex_q.valid, ex_q.wr, ex_q.dst, id_a);
    // Load data is not yet available on exmem_data, so a load in MEM never forwards.
    assign mem_fwd[g] = hit(mem_q.valid, mem_q.wr, mem_q.dst, addr_q) && !mem_q.load;
    assign wb_fwd[g]  = !mem_fwd[g] && hit(wb_valid, wb_wr, wb_dst, addr_q);

    assign ex_op[g*DATA_W +: DATA_W] = mem_fwd[g] ? exmem_data :
                                       wb_fwd[g]  ? memwb_data : op_q;
    assign fwd_sel[g*2 +: 2]         = mem_fwd[g] ? 2'b10 :
                                       wb_fwd[g]  ? 2'b01 : 2'b00;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        op_q   <= '0;
        addr_q <= '0;
      end else if (advance) begin
        addr_q <= id_a;
        op_q   <= hit(wb_valid, wb_wr, wb_dst, id_a) ? memwb_data
                                                     : id_src_data[g*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_q     <= '0;
      mem_q    <= '0;
      wb_valid <= 1'b0;
      wb_dst   <= '0;
      wb_wr    <= 1'b0;
    end else begin
      mem_q    <= ex_q;
      wb_valid <= mem_q.valid;
      wb_dst   <= mem_q.dst;
      wb_wr    <= mem_q.wr;
      if (advance) begin
        ex_q <= '{valid: id_valid, dst: id_dst_addr, wr: id_wr_en, load: id_is_load};
      end else begin
        ex_q <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= RUN;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (stall) state_d = STALL;
      STALL:   state_d = stall ? STALL : RUN;
      default: state_d = RUN;
    endcase
  end

  // During STALL the bubble in EX keeps the stalled pair quiet; a new load hazard still stalls.
  always_comb begin
    stall = 1'b0;
    case (state_q)
      RUN, STALL: stall = hazard && !flush;
      default:    stall = 1'b0;
    endcase
  end

  assign ex_valid    = ex_q.valid;
  assign ex_dst_addr = ex_q.dst;
  assign ex_wr_en    = ex_q.valid && ex_q.wr;

`ifdef FWD_STATS_EN
  function automatic logic [15:0] sat_add(input logic [15:0] c, input logic [15:0] n);
    logic [16:0] s;
    s = {1'b0, c} + {1'b0, n};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_fwd_mem <= '0;
      stat_fwd_wb  <= '0;
      stat_stall   <= '0;
    end else begin
      if (ex_q.valid) begin
        stat_fwd_mem <= sat_add(stat_fwd_mem, 16'($countones(mem_fwd)));
        stat_fwd_wb  <= sat_add(stat_fwd_wb, 16'($countones(wb_fwd)));
      end
      stat_stall <= sat_add(stat_stall, {15'b0, stall});
    end
  end
`endif

endmodule

// File: tb/tb_fwd_stall_unit.sv
// Scoreboard bench for fwd_stall_unit: expectations queued at stimulus time, checked after settling.
module tb_fwd_stall_unit;
  localparam int DW = 16;
  localparam int AW = 4;
  localparam int NS = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             id_valid;
  logic [NS*AW-1:0] id_src_addr;
  logic [NS-1:0]    id_src_used;
  logic [NS*DW-1:0] id_src_data;
  logic [AW-1:0]    id_dst_addr;
  logic             id_wr_en, id_is_load, flush;
  logic [DW-1:0]    exmem_data, memwb_data;
  logic [NS*DW-1:0] ex_op;
  logic [NS*2-1:0]  fwd_sel;
  logic             stall, ex_valid, ex_wr_en;
  logic [AW-1:0]    ex_dst_addr;
`ifdef FWD_STATS_EN
  logic [15:0]      stat_fwd_mem, stat_fwd_wb, stat_stall;
`endif

  always #5 clk = ~clk;

  fwd_stall_unit #(.DATA_W(DW), .REG_AW(AW), .NUM_SRC(NS), .ZERO_REG(1)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_src_addr(id_src_addr),
    .id_src_used(id_src_used), .id_src_data(id_src_data), .id_dst_addr(id_dst_addr),
    .id_wr_en(id_wr_en), .id_is_load(id_is_load), .flush(flush),
    .exmem_data(exmem_data), .memwb_data(memwb_data), .ex_op(ex_op), .fwd_sel(fwd_sel),
    .stall(stall), .ex_valid(ex_valid), .ex_dst_addr(ex_dst_addr), .ex_wr_en(ex_wr_en)
`ifdef FWD_STATS_EN
    , .stat_fwd_mem(stat_fwd_mem), .stat_fwd_wb(stat_fwd_wb), .stat_stall(stat_stall)
`endif
  );

  typedef enum int {S_OP0, S_OP1, S_SEL0, S_SEL1, S_STALL, S_EXV, S_EXDST, S_EXWR} sig_e;
  typedef struct {
    string       tag;
    sig_e        sig;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
  endtask

  function automatic logic [31:0] observe(input sig_e s);
    case (s)
      S_OP0:   return {16'h0, ex_op[15:0]};
      S_OP1:   return {16'h0, ex_op[31:16]};
      S_SEL0:  return {30'h0, fwd_sel[1:0]};
      S_SEL1:  return {30'h0, fwd_sel[3:2]};
      S_STALL: return {31'h0, stall};
      S_EXV:   return {31'h0, ex_valid};
      S_EXDST: return {28'h0, ex_dst_addr};
      S_EXWR:  return {31'h0, ex_wr_en};
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  task automatic push_exp(input string tag, input sig_e s, input logic [31:0] v);
    sb.push_back('{tag, s, v});
  endtask

  task automatic drain();
    exp_t e;
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check_eq(e.tag, observe(e.sig), e.exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] a0, input logic [3:0] a1, input logic [1:0] used,
                       input logic [15:0] d0, input logic [15:0] d1,
                       input logic [3:0] dst, input logic wr, input logic ld);
    id_valid    = 1'b1;
    id_src_addr = {a1, a0};
    id_src_used = used;
    id_src_data = {d1, d0};
    id_dst_addr = dst;
    id_wr_en    = wr;
    id_is_load  = ld;
  endtask

  task automatic idle();
    id_valid    = 1'b0;
    id_src_addr = '0;
    id_src_used = '0;
    id_src_data = '0;
    id_dst_addr = '0;
    id_wr_en    = 1'b0;
    id_is_load  = 1'b0;
  endtask

  task automatic idle_n(input int n);
    idle();
    repeat (n) tick();
  endtask

  task automatic push_all_zero(input string pfx);
    push_exp({pfx, "_op0"}, S_OP0, 0);
    push_exp({pfx, "_op1"}, S_OP1, 0);
    push_exp({pfx, "_sel0"}, S_SEL0, 0);
    push_exp({pfx, "_sel1"}, S_SEL1, 0);
    push_exp({pfx, "_stall"}, S_STALL, 0);
    push_exp({pfx, "_exv"}, S_EXV, 0);
    push_exp({pfx, "_exdst"}, S_EXDST, 0);
    push_exp({pfx, "_exwr"}, S_EXWR, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; exmem_data = 16'hE0E0; memwb_data = 16'hB0B0;
    idle();
    tick(); tick();
    rst_n = 1'b1;
    push_all_zero("reset");
    drain();

    // ADD r1 then SUB reading r1: MEM forward
    issue(4'd6, 4'd7, 2'b11, 16'h0011, 16'h0022, 4'd1, 1'b1, 1'b0);
    push_exp("add_nostall", S_STALL, 0);
    drain();
    tick();
    push_exp("add_exv", S_EXV, 1);
    push_exp("add_exdst", S_EXDST, 1);
    push_exp("add_exwr", S_EXWR, 1);
    push_exp("add_op0", S_OP0, 16'h0011);
    issue(4'd1, 4'd6, 2'b11, 16'h0000, 16'h0011, 4'd8, 1'b1, 1'b0);
    push_exp("sub_nostall", S_STALL, 0);
    drain();
    tick();
    exmem_data = 16'h1234;
    idle();
    push_exp("sub_sel0", S_SEL0, 2'b10);
    push_exp("sub_op0", S_OP0, 16'h1234);
    push_exp("sub_sel1", S_SEL1, 2'b00);
    push_exp("sub_op1", S_OP1, 16'h0011);
    drain();
    idle_n(3);

    // r2 written two instructions back: WB forward
    issue(4'd0, 4'd0, 2'b00, 16'h0, 16'h0, 4'd2, 1'b1, 1'b0); tick();
    issue(4'd0, 4'd0, 2'b00, 16'h0, 16'h0, 4'd9, 1'b1, 1'b0); tick();
    issue(4'd2, 4'd0, 2'b01, 16'h0000, 16'h0, 4'd10, 1'b1, 1'b0); tick();
    exmem_data = 16'h3333; memwb_data = 16'h00AA; idle();
    push_exp("wb_sel0", S_SEL0, 2'b01);
    push_exp("wb_op0", S_OP0, 16'h00AA);
    drain();
    idle_n(3);

    // both MEM and WB write r2: MEM wins
    issue(4'd0, 4'd0, 2'b00, 16'h0, 16'h0, 4'd2, 1'b1, 1'b0); tick();
    issue(4'd0, 4'd0, 2'b00, 16'h0, 16'h0, 4'd2, 1'b1, 1'b0); tick();
    issue(4'd2, 4'd0, 2'b01, 16'h0000, 16'h0, 4'd10, 1'b1, 1'b0); tick();
    exmem_data = 16'h5555; memwb_data = 16'h00AA; idle();
    push_exp("prio_sel0", S_SEL0, 2'b10);
    push_exp("prio_op0", S_OP0, 16'h5555);
    drain();
    idle_n(3);

    // load in MEM, reader marks operand unused: no stall, no forward from exmem_data
    issue(4'd0, 4'd0, 2'b01, 16'h0, 16'h0, 4'd3, 1'b1, 1'b1); tick();
    issue(4'd3, 4'd0, 2'b00, 16'h0123, 16'h0, 4'd11, 1'b1, 1'b0);
    push_exp("unused_nostall", S_STALL, 0);
    drain();
    tick();
    exmem_data = 16'h6666; memwb_data = 16'hB0B0; idle();
    push_exp("ldmem_sel0", S_SEL0, 2'b00);
    push_exp("ldmem_op0", S_OP0, 16'h0123);
    drain();
    idle_n(3);

    // LW r3 then ADD r3: one stall cycle with bubble, then WB forward
    issue(4'd0, 4'd0, 2'b01, 16'h0, 16'h0, 4'd3, 1'b1, 1'b1); tick();
    issue(4'd3, 4'd4, 2'b11, 16'h0000, 16'h0044, 4'd10, 1'b1, 1'b0);
    push_exp("lu_stall", S_STALL, 1);
    drain();
    tick();
    push_exp("lu_bubble", S_EXV, 0);
    push_exp("lu_stall_once", S_STALL, 0);
    drain();
    check_eq("lu_fsm_stall", 32'(dut.state_q), 1);
    tick();
    memwb_data = 16'hBEEF; exmem_data = 16'h6666; idle();
    push_exp("lu_exv", S_EXV, 1);
    push_exp("lu_exdst", S_EXDST, 10);
    push_exp("lu_sel0", S_SEL0, 2'b01);
    push_exp("lu_op0", S_OP0, 16'hBEEF);
    push_exp("lu_sel1", S_SEL1, 2'b00);
    push_exp("lu_op1", S_OP1, 16'h0044);
    drain();
    idle_n(3);

    // flush during the hazard cycle
    issue(4'd0, 4'd0, 2'b01, 16'h0, 16'h0, 4'd3, 1'b1, 1'b1); tick();
    issue(4'd3, 4'd4, 2'b11, 16'h0000, 16'h0044, 4'd10, 1'b1, 1'b0);
    flush = 1'b1;
    push_exp("flush_nostall", S_STALL, 0);
    drain();
    tick();
    flush = 1'b0; idle();
    push_exp("flush_exv", S_EXV, 0);
    drain();
    idle_n(3);

    // r0 is never forwarded and never a hazard
    issue(4'd0, 4'd0, 2'b00, 16'h0, 16'h0, 4'd0, 1'b1, 1'b0); tick();
    issue(4'd0, 4'd0, 2'b11, 16'h0000, 16'h0000, 4'd12, 1'b1, 1'b0); tick();
    exmem_data = 16'h7A7A; memwb_data = 16'h7B7B; idle();
    push_exp("r0_sel0", S_SEL0, 2'b00);
    push_exp("r0_op0", S_OP0, 16'h0000);
    push_exp("r0_sel1", S_SEL1, 2'b00);
    drain();
    idle_n(3);
    issue(4'd0, 4'd0, 2'b00, 16'h0, 16'h0, 4'd0, 1'b1, 1'b1); tick();
    issue(4'd0, 4'd0, 2'b11, 16'h0, 16'h0, 4'd12, 1'b1, 1'b0);
    push_exp("r0_load_nostall", S_STALL, 0);
    drain();
    idle_n(3);

    // WB writes r5 while ID reads it: bypassed capture
    issue(4'd0, 4'd0, 2'b00, 16'h0, 16'h0, 4'd5, 1'b1, 1'b0); tick();
    idle(); tick(); tick();
    issue(4'd5, 4'd0, 2'b01, 16'h0000, 16'h0, 4'd13, 1'b1, 1'b0);
    memwb_data = 16'h7777;
    push_exp("byp_nostall", S_STALL, 0);
    drain();
    tick();
    memwb_data = 16'h0BAD; exmem_data = 16'h0BAD; idle();
    push_exp("byp_sel0", S_SEL0, 2'b00);
    push_exp("byp_op0", S_OP0, 16'h7777);
    drain();
    idle_n(3);

    // reset asserted during a stall
    issue(4'd0, 4'd0, 2'b01, 16'h0, 16'h0, 4'd3, 1'b1, 1'b1); tick();
    issue(4'd3, 4'd4, 2'b11, 16'h0000, 16'h0044, 4'd10, 1'b1, 1'b0);
    push_exp("rst_pre_stall", S_STALL, 1);
    drain();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; idle();
    exmem_data = 16'h1111; memwb_data = 16'h2222;
    push_all_zero("rst_mid");
    drain();
    check_eq("rst_fsm_run", 32'(dut.state_q), 0);

`ifdef FWD_STATS_EN
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    issue(4'd0, 4'd0, 2'b00, 16'h0, 16'h0, 4'd1, 1'b1, 1'b0); tick();
    issue(4'd1, 4'd1, 2'b11, 16'h0, 16'h0, 4'd1, 1'b1, 1'b0); tick();
    issue(4'd1, 4'd0, 2'b01, 16'h0, 16'h0, 4'd2, 1'b1, 1'b0); tick();
    idle_n(4);
    repeat (2) begin
      issue(4'd0, 4'd0, 2'b00, 16'h0, 16'h0, 4'd3, 1'b1, 1'b1); tick();
      issue(4'd3, 4'd0, 2'b01, 16'h0, 16'h0, 4'd4, 1'b1, 1'b0); tick();
      tick();
      idle_n(4);
    end
    check_eq("stat_fwd_mem", {16'h0, stat_fwd_mem}, 3);
    check_eq("stat_fwd_wb", {16'h0, stat_fwd_wb}, 2);
    check_eq("stat_stall", {16'h0, stat_stall}, 2);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
